// File: rtl/scope_frame_capture.sv
// ADC capture front-end: gates and decimates the sample stream, optionally
// waits for a rising level trigger, and packs fixed-length frames onto AXIS.

module scope_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

module scope_frame_capture #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 32,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16,
    parameter int DEC_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         trig_mode,
    input  logic [DATA_W-1:0]            trig_level,
    input  logic [DEC_W-1:0]             decim,
    input  logic [DATA_W-1:0]            ad_data_in,
    output logic [DATA_W-1:0]            ad_data,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [OUT_W-1:0]             m_tdata,
    output logic                         m_tlast,
    output logic [$clog2(FRAME_LEN)-1:0] m_tuser,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int ENT_W = 1 + IDX_W + DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] s_reg;
    logic [DATA_W-1:0] prev_s;
    logic [DEC_W-1:0]  dec_q;
    logic [DEC_W-1:0]  dec_q_nxt;
    logic [DEC_W-1:0]  dec_cnt;
    logic [DEC_W-1:0]  dec_cnt_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic              arm_first;
    logic              arm_first_nxt;

    logic              push_req;
    logic              push;
    logic              pop;
    logic              fifo_ok;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ENT_W-1:0]  wr_ent;
    logic [ENT_W-1:0]  head;
    logic              trig_hit;

    // A full FIFO still accepts a write when the head leaves this cycle.
    assign pop     = m_tvalid & m_tready;
    assign fifo_ok = ~fifo_full | pop;
    assign push    = push_req & fifo_ok;
    assign wr_ent  = {(idx == LAST_IDX), idx, s_reg};

    assign trig_hit = ~arm_first
                    & (prev_s < trig_level)
                    & (s_reg >= trig_level);

    always_comb begin
        state_nxt     = state;
        dec_q_nxt     = dec_q;
        dec_cnt_nxt   = dec_cnt;
        idx_nxt       = idx;
        arm_first_nxt = 1'b0;
        push_req      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt     = trig_mode ? ARM : CAPTURE;
                    dec_q_nxt     = decim;
                    dec_cnt_nxt   = '0;
                    idx_nxt       = '0;
                    arm_first_nxt = 1'b1;
                end
            end
            ARM: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (trig_hit) begin
                    push_req    = 1'b1;
                    state_nxt   = CAPTURE;
                    dec_q_nxt   = decim;
                    dec_cnt_nxt = (decim == '0) ? '0 : DEC_W'(1);
                    if (push) begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                dec_cnt_nxt = (dec_cnt == dec_q) ? '0 : dec_cnt + 1'b1;
                if (dec_cnt == '0) begin
                    push_req = 1'b1;
                    // A dropped sample keeps its index for the next slot.
                    if (push) begin
                        idx_nxt = idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (pop && m_tlast) begin
                    idx_nxt       = '0;
                    dec_cnt_nxt   = '0;
                    dec_q_nxt     = decim;
                    arm_first_nxt = 1'b1;
                    if (!en) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = trig_mode ? ARM : CAPTURE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dec_q     <= '0;
            dec_cnt   <= '0;
            idx       <= '0;
            arm_first <= 1'b0;
            s_reg     <= '0;
            prev_s    <= '0;
            ad_data   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dec_q     <= dec_q_nxt;
            dec_cnt   <= dec_cnt_nxt;
            idx       <= idx_nxt;
            arm_first <= arm_first_nxt;
            s_reg     <= ad_data_in;
            prev_s    <= s_reg;
            ad_data   <= en ? ad_data_in : '0;
            if (push_req && !fifo_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    scope_frame_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_ent),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_tvalid   = ~fifo_empty;
    assign m_tdata    = m_tvalid ? OUT_W'(head[DATA_W-1:0]) : '0;
    assign m_tuser    = m_tvalid ? head[DATA_W +: IDX_W] : '0;
    assign m_tlast    = m_tvalid & head[ENT_W-1];
    assign frame_done = pop & m_tlast;
    assign busy       = (state != IDLE);

endmodule
